// File: rtl/mips_isa_pkg.sv
// ----------------------------------------------------------------------------
// mips_isa_pkg
// Purpose : MIPS opcode constants and small memory-access decode helpers
//           shared by the data memory, the load formatter and decode.
// Contents:
//   OP_LW/OP_LBU/OP_LHU/OP_SB/OP_SH/OP_SW   6-bit primary opcodes
//   acc_kind_e                              load / store / not-a-memory-op
//   acc_kind()                              opcode -> acc_kind_e
//   is_aligned()                            opcode + Addr[1:0] -> legal access
// ----------------------------------------------------------------------------
package mips_isa_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_e;

    function automatic acc_kind_e acc_kind(input logic [5:0] op);
        acc_kind_e k;
        case (op)
            OP_LW, OP_LBU, OP_LHU: k = ACC_LOAD;
            OP_SB, OP_SH, OP_SW:   k = ACC_STORE;
            default:               k = ACC_NONE;
        endcase
        return k;
    endfunction

    // Byte ops may use any offset, halfwords must not straddle the word
    // (offset 3), words must be word aligned.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
        logic ok;
        case (op)
            OP_LBU, OP_SB: ok = 1'b1;
            OP_LHU, OP_SH: ok = (off != 2'd3);
            OP_LW,  OP_SW: ok = (off == 2'd0);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// ----------------------------------------------------------------------------
// dmem_bank
// Purpose : one byte lane of the data memory. Single port, one write enable,
//           registered read data. The array itself is never reset; only the
//           read register is cleared by reset.
// Ports   :
//   i_clk    in   1            rising-edge clock
//   i_rst_n  in   1            synchronous reset, active low (read reg only)
//   i_we     in   1            write enable (write lands at the clock edge)
//   i_re     in   1            read enable (o_rdata updates at the clock edge)
//   i_addr   in   ADDR_WIDTH   word index
//   i_wdata  in   DATA_WIDTH   write data
//   o_rdata  out  DATA_WIDTH   registered read data, holds when i_re=0
// ----------------------------------------------------------------------------
module dmem_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_byte_banks.sv
// ----------------------------------------------------------------------------
// dmem_byte_banks
// Purpose : MEM-stage data memory built from four byte-wide banks
//           (lane 0 = Addr[1:0]==0). Steers byte/half/word stores onto lane
//           enables, reads all four lanes for loads (1-cycle latency), and
//           suppresses misaligned accesses, flagging them one cycle later.
// Ports   :
//   Clk          in   1           rising-edge clock
//   Rst_n        in   1           synchronous reset, active low
//   MemEn        in   1           MEM-stage instruction valid
//   Opcode       in   6           MIPS opcode of the MEM-stage instruction
//   Addr         in   32          byte address (upper bits wrap modulo depth)
//   WriteData    in   32          store data (rt)
//   Mem0Out..Mem3Out out DATA_WIDTH  registered lane read data
//   MemSel       out  2           registered Addr[1:0] of the last legal load
//   OpcodeOut    out  6           registered opcode of the last legal load
//   RdValid      out  1           lane outputs hold a load issued last cycle
//   MisalignErr  out  1           last cycle's access was misaligned, dropped
// Handshake: no valid/ready; MemEn qualifies one access per cycle, results
//   for a legal load appear the following cycle with RdValid=1. Lane data,
//   MemSel and OpcodeOut only change on a legal load or on reset.
// ----------------------------------------------------------------------------
module dmem_byte_banks
    import mips_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  MemEn,
    input  logic [5:0]            Opcode,
    input  logic [31:0]           Addr,
    input  logic [31:0]           WriteData,
    output logic [DATA_WIDTH-1:0] Mem0Out,
    output logic [DATA_WIDTH-1:0] Mem1Out,
    output logic [DATA_WIDTH-1:0] Mem2Out,
    output logic [DATA_WIDTH-1:0] Mem3Out,
    output logic [1:0]            MemSel,
    output logic [5:0]            OpcodeOut,
    output logic                  RdValid,
    output logic                  MisalignErr
);

    // ---------------- address / opcode decode ----------------
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_off;
    logic [1:0]            w_off_p1;
    acc_kind_e             w_kind;
    logic                  w_active;
    logic                  w_aligned;
    logic                  w_misalign;
    logic                  w_do_load;
    logic                  w_do_store;

    assign w_idx      = Addr[ADDR_WIDTH+1:2];
    assign w_off      = Addr[1:0];
    assign w_off_p1   = w_off + 2'd1;
    assign w_kind     = acc_kind(Opcode);
    assign w_active   = MemEn && (w_kind != ACC_NONE);
    assign w_aligned  = is_aligned(Opcode, w_off);
    assign w_misalign = w_active && !w_aligned;
    assign w_do_load  = w_active && w_aligned && (w_kind == ACC_LOAD);
    assign w_do_store = w_active && w_aligned && (w_kind == ACC_STORE);

    // High address bits are intentionally ignored so addresses wrap.
    logic w_unused;
    assign w_unused = &{1'b0, Addr[31:ADDR_WIDTH+2]};

    // ---------------- store steering ----------------
    logic [3:0]            w_lane_we;
    logic [DATA_WIDTH-1:0] w_lane_wd [4];

    always_comb begin
        w_lane_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_lane_wd[k] = WriteData[k*DATA_WIDTH +: DATA_WIDTH];
        end
        case (Opcode)
            OP_SB: begin
                w_lane_we[w_off] = 1'b1;
                w_lane_wd[w_off] = WriteData[DATA_WIDTH-1:0];
            end
            OP_SH: begin
                // off==3 never gets here enabled: it is misaligned and
                // w_do_store gates it off below, so off+1 cannot wrap.
                w_lane_we[w_off]    = 1'b1;
                w_lane_we[w_off_p1] = 1'b1;
                w_lane_wd[w_off]    = WriteData[DATA_WIDTH-1:0];
                w_lane_wd[w_off_p1] = WriteData[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_SW: begin
                w_lane_we = 4'b1111;
            end
            default: begin
                w_lane_we = 4'b0000;
            end
        endcase
        // Reset drops any store issued in the same cycle.
        if (!w_do_store || !Rst_n) begin
            w_lane_we = 4'b0000;
        end
    end

    // ---------------- banks ----------------
    logic [DATA_WIDTH-1:0] w_rdata [4];

    for (genvar g = 0; g < 4; g++) begin : g_bank
        dmem_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .i_clk   (Clk),
            .i_rst_n (Rst_n),
            .i_we    (w_lane_we[g]),
            .i_re    (w_do_load),
            .i_addr  (w_idx),
            .i_wdata (w_lane_wd[g]),
            .o_rdata (w_rdata[g])
        );
    end

    assign Mem0Out = w_rdata[0];
    assign Mem1Out = w_rdata[1];
    assign Mem2Out = w_rdata[2];
    assign Mem3Out = w_rdata[3];

    // ---------------- output pipeline registers ----------------
    logic [1:0] r_sel;
    logic [5:0] r_op;
    logic       r_rd_valid;
    logic       r_misalign;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_sel      <= 2'd0;
            r_op       <= 6'd0;
            r_rd_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_rd_valid <= w_do_load;
            r_misalign <= w_misalign;
            if (w_do_load) begin
                r_sel <= w_off;
                r_op  <= Opcode;
            end
        end
    end

    assign MemSel      = r_sel;
    assign OpcodeOut   = r_op;
    assign RdValid     = r_rd_valid;
    assign MisalignErr = r_misalign;

endmodule
